alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters. Each requester has a valid/ready command channel and a valid/ready response channel.
- Round-robin arbitration; one ALU operation outstanding at a time.
- Drives the ALU operand and function-code inputs, waits the ALU's fixed latency, captures the result and returns it to the granted requester.
- Sits between the ALU and its two client blocks.

Parameters:
- NBIT, 32, operand/result width.
- ALU_LAT, 1, ALU latency in clock edges from stable operands to result visible on i_alu_data (0 = combinational ALU).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_req0_valid / i_req1_valid  in  1  command valid per requester
- o_req0_ready / o_req1_ready  out  1  command accepted this cycle
- i_req0_a, i_req0_b / i_req1_a, i_req1_b  in  NBIT  operands
- i_req0_fc / i_req1_fc  in  4  function code
- o_rsp0_valid / o_rsp1_valid  out  1  response valid
- i_rsp0_ready / i_rsp1_ready  in  1  response consumed
- o_rsp0_data / o_rsp1_data  out  NBIT  result
- o_rsp0_cout / o_rsp1_cout  out  1  carry
- o_rsp0_err / o_rsp1_err  out  1  illegal function code
- o_alu_a, o_alu_b  out  NBIT  to ALU i_data_a/i_data_b
- o_alu_fc  out  4  to ALU i_fc
- i_alu_data  in  NBIT  from ALU o_data
- i_alu_cout  in  1  from ALU o_cout
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = 1, so req0 wins the first tie. Reset is asynchronous: any in-flight operation is dropped and no response is issued.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration:
  - Only one valid → grant it.
  - Both valid → grant the requester != last_grant.
  - o_reqN_ready = (state==IDLE) && grant==N, combinational, never both high.
  - Requesters hold valid and payload stable until ready. Deasserting valid before ready is legal: the command is withdrawn.
- Accept edge T0 (valid && ready):
  - Latch a, b, fc into o_alu_a/o_alu_b/o_alu_fc.
  - last_grant <= N; owner <= N.
- Legal fc set: 4'b0000, 0001, 0010, 0100, 0101, 0110, 0111. Anything else is illegal.
- Legal fc → EXEC:
  - Counter loaded with ALU_LAT; decrements each cycle in EXEC.
  - At the edge where counter==0 (T0+ALU_LAT+1), capture i_alu_data/i_alu_cout into the owner's response registers, set err=0, go to RESP.
- Illegal fc:
  - o_alu_* are not updated and the ALU is not used.
  - Go directly to RESP at T0 with data=0, cout=0, err=1.
  - Response valid from the cycle after T0.
- RESP:
  - o_rspOWNER_valid = 1; data/cout/err held stable.
  - The other requester's rsp_valid stays 0.
  - On valid && ready edge: clear valid, return to IDLE.
  - i_rspN_ready may be high in advance; the transfer then occurs on the first RESP edge.
- Back-to-back timing:
  - With immediate rsp ready and a pending request, the next accept occurs on the first IDLE cycle after the transfer edge.
  - Accepts for legal ops are spaced ALU_LAT+3 cycles apart.
- o_alu_a/b/fc hold their last values in IDLE, RESP and after illegal ops: no toggling without an issue.
- While busy: both req_ready = 0; new valids wait with no loss.
- Counter width: clog2(ALU_LAT+1), min 1 bit. ALU_LAT=0 is supported: capture at T0+1.
- The block performs no arithmetic; data pass through at width NBIT unchanged.

Test Plan:
- Single add, ALU_LAT=1:
  - Stimulus: req0 a=32'h0000_0005, b=32'h0000_0003, fc=4'b0010, rsp0_ready=1.
  - Required: ready0 high one cycle; o_alu_fc=0010 after T0; o_rsp0_valid at T0+2 with data=8, cout=0, err=0; rsp1_valid never rises.
- Tie, round-robin:
  - Stimulus: both valid continuously, each issuing 3 ops.
  - Required: grant order 0,1,0,1,0,1; each response goes only to its owner; legal-op accepts spaced 4 cycles apart.
- Carry and backpressure:
  - Stimulus: req1 a=32'hFFFF_FFFF, b=1, fc=0010; rsp1_ready held low for 5 cycles.
  - Required: rsp1 data=0, cout=1, held stable all 5 cycles; req0_ready=0 throughout; o_busy=1.
- Illegal fc:
  - Stimulus: req0 fc=4'b0011.
  - Required: rsp0_valid the cycle after accept with data=0, cout=0, err=1; o_alu_* unchanged from the previous op.
- Reset mid-EXEC:
  - Stimulus: drop i_rstn one cycle after accept.
  - Required: all outputs 0 immediately; no response issued; after release, a tie grants req0 first.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin
// arbitration and a single operation outstanding at a time. Commands are
// accepted in IDLE, the ALU result is captured after its fixed latency and
// returned on the owning requester's response channel.

module alu_arbiter #(
  parameter int unsigned NBIT    = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  // requester 0 command channel
  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [NBIT-1:0] i_req0_a,
  input  logic [NBIT-1:0] i_req0_b,
  input  logic [3:0]      i_req0_fc,
  // requester 1 command channel
  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [NBIT-1:0] i_req1_a,
  input  logic [NBIT-1:0] i_req1_b,
  input  logic [3:0]      i_req1_fc,
  // requester 0 response channel
  output logic            o_rsp0_valid,
  input  logic            i_rsp0_ready,
  output logic [NBIT-1:0] o_rsp0_data,
  output logic            o_rsp0_cout,
  output logic            o_rsp0_err,
  // requester 1 response channel
  output logic            o_rsp1_valid,
  input  logic            i_rsp1_ready,
  output logic [NBIT-1:0] o_rsp1_data,
  output logic            o_rsp1_cout,
  output logic            o_rsp1_err,
  // shared ALU
  output logic [NBIT-1:0] o_alu_a,
  output logic [NBIT-1:0] o_alu_b,
  output logic [3:0]      o_alu_fc,
  input  logic [NBIT-1:0] i_alu_data,
  input  logic            i_alu_cout,
  // status
  output logic            o_busy
);

  localparam int unsigned CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             owner;
  logic [CNT_W-1:0] cnt;

  logic             grant;
  logic             accept;
  logic             acc_legal;
  logic [NBIT-1:0]  acc_a;
  logic [NBIT-1:0]  acc_b;
  logic [3:0]       acc_fc;
  logic             rsp_done;

  // Per-requester response registers, indexed by requester number
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_cout;
  logic [1:0]       rsp_err;
  logic [NBIT-1:0]  rsp_data [2];

  function automatic logic fc_legal(input logic [3:0] fc);
    case (fc)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101, 4'b0110, 4'b0111: fc_legal = 1'b1;
      default:                            fc_legal = 1'b0;
    endcase
  endfunction

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant = ~last_grant;
    end else if (i_req1_valid) begin
      grant = 1'b1;
    end
  end

  // Ready is gated by reset so every output reads 0 while reset is held
  assign o_req0_ready = i_rstn && (state == IDLE) && i_req0_valid && !grant;
  assign o_req1_ready = i_rstn && (state == IDLE) && i_req1_valid &&  grant;
  assign accept       = o_req0_ready || o_req1_ready;

  // Payload of the granted requester
  always_comb begin
    acc_a  = i_req0_a;
    acc_b  = i_req0_b;
    acc_fc = i_req0_fc;
    if (grant) begin
      acc_a  = i_req1_a;
      acc_b  = i_req1_b;
      acc_fc = i_req1_fc;
    end
  end

  assign acc_legal = fc_legal(acc_fc);
  assign rsp_done  = owner ? i_rsp1_ready : i_rsp0_ready;
  assign o_busy    = (state != IDLE);

  assign o_rsp0_valid = rsp_valid[0];
  assign o_rsp0_data  = rsp_data[0];
  assign o_rsp0_cout  = rsp_cout[0];
  assign o_rsp0_err   = rsp_err[0];
  assign o_rsp1_valid = rsp_valid[1];
  assign o_rsp1_data  = rsp_data[1];
  assign o_rsp1_cout  = rsp_cout[1];
  assign o_rsp1_err   = rsp_err[1];

  // Arbitration FSM: accept, launch operands, wait out the ALU latency, respond
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      cnt         <= '0;
      o_alu_a     <= '0;
      o_alu_b     <= '0;
      o_alu_fc    <= '0;
      rsp_valid   <= '0;
      rsp_cout    <= '0;
      rsp_err     <= '0;
      rsp_data[0] <= '0;
      rsp_data[1] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            owner      <= grant;
            if (acc_legal) begin
              o_alu_a  <= acc_a;
              o_alu_b  <= acc_b;
              o_alu_fc <= acc_fc;
              cnt      <= CNT_W'(ALU_LAT);
              state    <= EXEC;
            end else begin
              // Illegal code never reaches the ALU; answer immediately with an error
              rsp_valid[grant] <= 1'b1;
              rsp_data[grant]  <= '0;
              rsp_cout[grant]  <= 1'b0;
              rsp_err[grant]   <= 1'b1;
              state            <= RESP;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_valid[owner] <= 1'b1;
            rsp_data[owner]  <= i_alu_data;
            rsp_cout[owner]  <= i_alu_cout;
            rsp_err[owner]   <= 1'b0;
            state            <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            rsp_valid[owner] <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: table of single transactions, directed corner
// sequences, and a randomized phase checked every cycle by a transaction-level
// model of the arbiter's externally visible behaviour.

module tb_alu_arbiter;

  localparam int unsigned NBIT    = 32;
  localparam int unsigned ALU_LAT = 1;

  logic            clk;
  logic            rstn;
  logic            v0, v1;
  logic [NBIT-1:0] a0, b0, a1, b1;
  logic [3:0]      fc0, fc1;
  logic            rr0, rr1;

  logic            req0_ready, req1_ready;
  logic            rsp0_valid, rsp1_valid;
  logic [NBIT-1:0] rsp0_data, rsp1_data;
  logic            rsp0_cout, rsp1_cout, rsp0_err, rsp1_err;
  logic [NBIT-1:0] alu_a, alu_b, alu_data;
  logic [3:0]      alu_fc;
  logic            alu_cout;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  alu_arbiter #(.NBIT(NBIT), .ALU_LAT(ALU_LAT)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_req0_valid (v0),
    .o_req0_ready (req0_ready),
    .i_req0_a     (a0),
    .i_req0_b     (b0),
    .i_req0_fc    (fc0),
    .i_req1_valid (v1),
    .o_req1_ready (req1_ready),
    .i_req1_a     (a1),
    .i_req1_b     (b1),
    .i_req1_fc    (fc1),
    .o_rsp0_valid (rsp0_valid),
    .i_rsp0_ready (rr0),
    .o_rsp0_data  (rsp0_data),
    .o_rsp0_cout  (rsp0_cout),
    .o_rsp0_err   (rsp0_err),
    .o_rsp1_valid (rsp1_valid),
    .i_rsp1_ready (rr1),
    .o_rsp1_data  (rsp1_data),
    .o_rsp1_cout  (rsp1_cout),
    .o_rsp1_err   (rsp1_err),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_fc     (alu_fc),
    .i_alu_data   (alu_data),
    .i_alu_cout   (alu_cout),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: {cout, data}
  function automatic logic [NBIT:0] alu_fn(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                           input logic [3:0] fc);
    case (fc)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a} + {1'b0, b};
      4'b0100: return {1'b0, a ^ b};
      4'b0101: return {(a < b), a - b};
      4'b0110: return {a, 1'b0};
      4'b0111: return {1'b0, ~a};
      default: return '0;
    endcase
  endfunction

  generate
    if (ALU_LAT == 0) begin : g_comb_alu
      assign {alu_cout, alu_data} = alu_fn(alu_a, alu_b, alu_fc);
    end else begin : g_pipe_alu
      logic [NBIT:0] pipe [ALU_LAT];
      always @(posedge clk) begin
        pipe[0] <= alu_fn(alu_a, alu_b, alu_fc);
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign {alu_cout, alu_data} = pipe[ALU_LAT-1];
    end
  endgenerate

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int              cyc = 0;
  int              n_xfer = 0;
  bit              m_busy = 1'b0;
  bit              m_last = 1'b1;
  bit              e_owner;
  int              e_due;
  logic [NBIT-1:0] e_data;
  logic            e_cout, e_err;
  logic [NBIT-1:0] m_alu_a = '0, m_alu_b = '0;
  logic [3:0]      m_alu_fc = '0;
  logic            er0, er1, ev0, ev1, mn;
  logic [NBIT:0]   mres;
  logic [NBIT-1:0] ma, mb;
  logic [3:0]      mfc;

  // Every falling edge: compare all outputs against the model, then advance it
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("reset_outputs_zero",
          64'(|{req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
                rsp0_cout, rsp1_cout, rsp0_err, rsp1_err, alu_a, alu_b, alu_fc, busy}), 64'd0);
      m_busy = 1'b0; m_last = 1'b1;
      m_alu_a = '0; m_alu_b = '0; m_alu_fc = '0;
    end else begin
      er0 = !m_busy && v0 && (!v1 || m_last);
      er1 = !m_busy && v1 && (!v0 || !m_last);
      ev0 = m_busy && !e_owner && (cyc >= e_due);
      ev1 = m_busy &&  e_owner && (cyc >= e_due);
      chk("req0_ready", 64'(req0_ready), 64'(er0));
      chk("req1_ready", 64'(req1_ready), 64'(er1));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("alu_a", 64'(alu_a), 64'(m_alu_a));
      chk("alu_b", 64'(alu_b), 64'(m_alu_b));
      chk("alu_fc", 64'(alu_fc), 64'(m_alu_fc));
      chk("rsp0_valid", 64'(rsp0_valid), 64'(ev0));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(ev1));
      if (ev0) begin
        chk("rsp0_data", 64'(rsp0_data), 64'(e_data));
        chk("rsp0_cout_err", 64'({rsp0_cout, rsp0_err}), 64'({e_cout, e_err}));
      end
      if (ev1) begin
        chk("rsp1_data", 64'(rsp1_data), 64'(e_data));
        chk("rsp1_cout_err", 64'({rsp1_cout, rsp1_err}), 64'({e_cout, e_err}));
      end
      if ((ev0 && rr0) || (ev1 && rr1)) begin
        m_busy = 1'b0;
        n_xfer++;
      end else if (er0 || er1) begin
        mn  = er1;
        ma  = mn ? a1 : a0;
        mb  = mn ? b1 : b0;
        mfc = mn ? fc1 : fc0;
        m_last  = mn;
        e_owner = mn;
        m_busy  = 1'b1;
        if (mfc inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111}) begin
          mres = alu_fn(ma, mb, mfc);
          {e_cout, e_data} = mres;
          e_err = 1'b0;
          e_due = cyc + ALU_LAT + 2;
          m_alu_a = ma; m_alu_b = mb; m_alu_fc = mfc;
        end else begin
          e_data = '0; e_cout = 1'b0; e_err = 1'b1;
          e_due = cyc + 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                       input logic [3:0] fc);
    logic got;
    got = 1'b0;
    if (r == 0) begin v0 = 1'b1; a0 = a; b0 = b; fc0 = fc; end
    else        begin v1 = 1'b1; a1 = a; b1 = b; fc1 = fc; end
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = (r == 0) ? req0_ready : req1_ready;
      tick();
    end
    if (r == 0) v0 = 1'b0; else v1 = 1'b0;
    chk($sformatf("accept_seen_r%0d", r), 64'(got), 64'd1);
  endtask

  task automatic get_rsp(input int r, output logic [NBIT-1:0] d, output logic c, output logic e);
    logic got;
    got = 1'b0;
    d = '0; c = 1'b0; e = 1'b0;
    if (r == 0) rr0 = 1'b1; else rr1 = 1'b1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = (r == 0) ? rsp0_valid : rsp1_valid;
      if (got) begin
        d = (r == 0) ? rsp0_data : rsp1_data;
        c = (r == 0) ? rsp0_cout : rsp1_cout;
        e = (r == 0) ? rsp0_err  : rsp1_err;
      end
      tick();
    end
    if (r == 0) rr0 = 1'b0; else rr1 = 1'b0;
    chk($sformatf("rsp_seen_r%0d", r), 64'(got), 64'd1);
  endtask

  typedef struct {
    int unsigned     req;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic [3:0]      fc;
    logic [NBIT-1:0] data;
    logic            cout;
    logic            err;
  } vec_t;

  vec_t            tbl [12];
  logic [3:0]      legal_fc [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
  logic [NBIT-1:0] rd;
  logic            rc, re;
  logic            acc0, acc1;
  int              order [6];
  int              acc_t [6];
  int              na, tt, left0, left1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{0, 32'h0000_0005, 32'h0000_0003, 4'b0010, 32'h0000_0008, 1'b0, 1'b0};
    tbl[1]  = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000, 32'h0000_00F0, 1'b0, 1'b0};
    tbl[3]  = '{1, 32'h0000_F000, 32'h0000_000F, 4'b0001, 32'h0000_F00F, 1'b0, 1'b0};
    tbl[4]  = '{0, 32'h0000_AAAA, 32'h0000_FFFF, 4'b0100, 32'h0000_5555, 1'b0, 1'b0};
    tbl[5]  = '{1, 32'h0000_0010, 32'h0000_0003, 4'b0101, 32'h0000_000D, 1'b0, 1'b0};
    tbl[6]  = '{0, 32'h0000_0003, 32'h0000_0005, 4'b0101, 32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[7]  = '{1, 32'h8000_0001, 32'h0000_1234, 4'b0110, 32'h0000_0002, 1'b1, 1'b0};
    tbl[8]  = '{0, 32'h0000_FFFF, 32'h0000_0000, 4'b0111, 32'hFFFF_0000, 1'b0, 1'b0};
    tbl[9]  = '{1, 32'h0000_0001, 32'h0000_0002, 4'b0011, 32'h0000_0000, 1'b0, 1'b1};
    tbl[10] = '{0, 32'h0000_0001, 32'h0000_0002, 4'b1111, 32'h0000_0000, 1'b0, 1'b1};
    tbl[11] = '{1, 32'h0000_0003, 32'h0000_0004, 4'b1000, 32'h0000_0000, 1'b0, 1'b1};

    v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; fc0 = '0; fc1 = '0;
    rr0 = 1'b0; rr1 = 1'b0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // ---- single add, response ready in advance ----
    rr0 = 1'b1; v0 = 1'b1; a0 = 32'h5; b0 = 32'h3; fc0 = 4'b0010;
    @(negedge clk);
    chk("add_ready0", 64'(req0_ready), 64'd1);
    chk("add_ready1", 64'(req1_ready), 64'd0);
    tick();
    v0 = 1'b0;
    @(negedge clk);
    chk("add_ready0_drop", 64'(req0_ready), 64'd0);
    chk("add_alu_fc", 64'(alu_fc), 64'h2);
    chk("add_alu_ab", 64'({alu_a, alu_b}), {32'h5, 32'h3});
    chk("add_rsp_early0", 64'(rsp0_valid), 64'd0);
    @(negedge clk);
    chk("add_rsp_early1", 64'(rsp0_valid), 64'd0);
    @(negedge clk);
    chk("add_rsp_valid", 64'(rsp0_valid), 64'd1);
    chk("add_rsp_data", 64'(rsp0_data), 64'd8);
    chk("add_rsp_cout_err", 64'({rsp0_cout, rsp0_err}), 64'd0);
    @(negedge clk);
    chk("add_rsp_consumed", 64'(rsp0_valid), 64'd0);
    chk("add_idle", 64'(busy), 64'd0);
    tick();
    rr0 = 1'b0;

    // ---- table of single transactions ----
    for (int i = 0; i < 12; i++) begin
      issue(int'(tbl[i].req), tbl[i].a, tbl[i].b, tbl[i].fc);
      get_rsp(int'(tbl[i].req), rd, rc, re);
      chk($sformatf("tbl%0d_data", i), 64'(rd), 64'(tbl[i].data));
      chk($sformatf("tbl%0d_cout", i), 64'(rc), 64'(tbl[i].cout));
      chk($sformatf("tbl%0d_err", i), 64'(re), 64'(tbl[i].err));
    end

    // ---- carry with response backpressure, req0 waiting ----
    issue(1, 32'hFFFF_FFFF, 32'h1, 4'b0010);
    v0 = 1'b1; a0 = 32'h12; b0 = 32'h34; fc0 = 4'b0010;
    begin : wait_bp
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        seen = rsp1_valid;
        if (!seen) tick();
      end
      chk("bp_rsp_seen", 64'(seen), 64'd1);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", 64'(rsp1_valid), 64'd1);
      chk("bp_data", 64'(rsp1_data), 64'd0);
      chk("bp_cout_err", 64'({rsp1_cout, rsp1_err}), 64'b10);
      chk("bp_req0_blocked", 64'(req0_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
    end
    tick();
    rr1 = 1'b1;
    issue(0, 32'h12, 32'h34, 4'b0010);
    rr1 = 1'b0;
    get_rsp(0, rd, rc, re);
    chk("bp_follow_data", 64'(rd), 64'h46);

    // ---- illegal code leaves ALU operands untouched ----
    issue(0, 32'hDEAD, 32'hBEEF, 4'b0011);
    @(negedge clk);
    chk("ill_valid", 64'(rsp0_valid), 64'd1);
    chk("ill_data", 64'(rsp0_data), 64'd0);
    chk("ill_cout_err", 64'({rsp0_cout, rsp0_err}), 64'b01);
    chk("ill_alu_ab", 64'({alu_a, alu_b}), {32'h12, 32'h34});
    chk("ill_alu_fc", 64'(alu_fc), 64'h2);
    tick();
    get_rsp(0, rd, rc, re);

    // ---- reset during EXEC, then tie after release ----
    issue(1, 32'h7, 32'h9, 4'b0010);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("rst_async_zero",
        64'(|{req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
              rsp0_cout, rsp1_cout, rsp0_err, rsp1_err, alu_a, alu_b, alu_fc, busy}), 64'd0);
    v0 = 1'b1; a0 = 32'd1; b0 = 32'd100; fc0 = 4'b0010;
    v1 = 1'b1; a1 = 32'd2; b1 = 32'd200; fc1 = 4'b0010;
    rr0 = 1'b1; rr1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    na = 0; tt = 0; left0 = 3; left1 = 3;
    while (na < 6 && tt < 200) begin
      @(negedge clk);
      tt++;
      acc0 = v0 && req0_ready;
      acc1 = v1 && req1_ready;
      chk("tie_no_stale_rsp", 64'(rsp1_valid && tt < 3), 64'd0);
      if (acc0 || acc1) begin
        order[na] = acc1 ? 1 : 0;
        acc_t[na] = tt;
        na++;
      end
      tick();
      if (acc0) begin left0--; if (left0 == 0) v0 = 1'b0; else a0 = a0 + 32'd10; end
      if (acc1) begin left1--; if (left1 == 0) v1 = 1'b0; else a1 = a1 + 32'd10; end
    end
    chk("tie_accepts", 64'(na), 64'd6);
    for (int i = 0; i < na; i++) begin
      chk($sformatf("tie_order%0d", i), 64'(order[i]), 64'(i % 2));
      if (i > 0) chk($sformatf("tie_spacing%0d", i), 64'(acc_t[i] - acc_t[i-1]), 64'(ALU_LAT + 3));
    end
    repeat (10) tick();
    rr0 = 1'b0; rr1 = 1'b0;

    // ---- randomized traffic against the model ----
    acc0 = 1'b0; acc1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc0 = v0 && req0_ready;
      acc1 = v1 && req1_ready;
      tick();
      if (v0 && !acc0) begin
        if ($urandom_range(15) == 0) v0 = 1'b0;
      end else begin
        v0  = 1'($urandom_range(1));
        a0  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b0  = 32'($urandom);
        fc0 = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : legal_fc[$urandom_range(6)];
      end
      if (v1 && !acc1) begin
        if ($urandom_range(15) == 0) v1 = 1'b0;
      end else begin
        v1  = 1'($urandom_range(1));
        a1  = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b1  = 32'($urandom);
        fc1 = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : legal_fc[$urandom_range(6)];
      end
      rr0 = ($urandom_range(2) != 0);
      rr1 = ($urandom_range(2) != 0);
    end
    v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1; rr1 = 1'b1;
    repeat (20) tick();
    chk("random_traffic_flowed", 64'(n_xfer > 100), 64'd1);
    chk("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
